// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single spi_sram controller.
// Write bursts are streamed into the controller FIFO before the command is
// issued; read bursts are drained from the controller FIFO after it reports
// done. All outputs are registered and only one command is ever outstanding.
module sram_arbiter #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_write,
    input  logic [47:0] req_addr,
    input  logic [11:0] req_len,
    input  logic [15:0] wdata,
    input  logic [1:0]  wdata_valid,
    output logic [1:0]  wdata_ready,
    output logic [7:0]  rdata,
    output logic [1:0]  rdata_valid,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    input  logic        sram_done,
    output logic [7:0]  sram_data_in,
    output logic        sram_data_in_valid,
    input  logic [7:0]  sram_data_out,
    output logic        sram_data_out_read,
    input  logic        sram_data_out_empty,
    output logic        sram_write_cmd,
    output logic        sram_read_cmd,
    output logic [5:0]  sram_read_cmd_size,
    output logic [23:0] sram_address
);

    localparam logic [5:0] MaxLen = 6'(MAX_LEN);

    typedef enum logic [3:0] {
        StInit,
        StIdle,
        StLoad,
        StFlush,
        StIssue,
        StSettle,
        StWait,
        StDrain,
        StDone
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic        write_q;
    logic [5:0]  len_q;
    logic [5:0]  cnt_q;   // bytes accepted in LOAD, pops issued in DRAIN
    logic [5:0]  rcnt_q;  // read bytes returned to the owner
    logic        pop_q;   // a pop was issued last cycle, data is valid now

    logic        gnt_next;
    logic [1:0]  next_oh;
    logic [1:0]  gnt_oh;
    logic        cand_write;
    logic [5:0]  cand_len;
    logic [23:0] cand_addr;
    logic        cand_bad;
    logic [7:0]  wbyte;
    logic        accept;

    // Arbitration choice and per-owner input selection
    always_comb begin
        gnt_next = 1'b0;
        if (req == 2'b11) begin
            gnt_next = ~last_grant_q;
        end else if (req[1]) begin
            gnt_next = 1'b1;
        end
        next_oh    = gnt_next ? 2'b10 : 2'b01;
        cand_write = req_write[gnt_next];
        cand_len   = gnt_next ? req_len[11:6] : req_len[5:0];
        cand_addr  = gnt_next ? req_addr[47:24] : req_addr[23:0];
        cand_bad   = (cand_len == 6'd0) || (cand_len > MaxLen);
        gnt_oh     = gnt_q ? 2'b10 : 2'b01;
        wbyte      = gnt_q ? wdata[15:8] : wdata[7:0];
        accept     = |(wdata_valid & wdata_ready & gnt_oh);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StInit;
            last_grant_q       <= 1'b1;
            gnt_q              <= 1'b0;
            write_q            <= 1'b0;
            len_q              <= '0;
            cnt_q              <= '0;
            rcnt_q             <= '0;
            pop_q              <= 1'b0;
            wdata_ready        <= '0;
            rdata              <= '0;
            rdata_valid        <= '0;
            req_done           <= '0;
            req_err            <= '0;
            sram_data_in       <= '0;
            sram_data_in_valid <= 1'b0;
            sram_data_out_read <= 1'b0;
            sram_write_cmd     <= 1'b0;
            sram_read_cmd      <= 1'b0;
            sram_read_cmd_size <= '0;
            sram_address       <= '0;
        end else begin
            // Strobes default low; states that need them re-assert each cycle
            wdata_ready        <= '0;
            rdata_valid        <= '0;
            req_done           <= '0;
            req_err            <= '0;
            sram_data_in_valid <= 1'b0;
            sram_data_out_read <= 1'b0;
            sram_write_cmd     <= 1'b0;
            sram_read_cmd      <= 1'b0;
            pop_q              <= sram_data_out_read;

            unique case (state_q)
                StInit: begin
                    // Controller signals done once its own init sequence ends
                    if (sram_done) begin
                        state_q <= StIdle;
                    end
                end

                StIdle: begin
                    if (|req) begin
                        gnt_q        <= gnt_next;
                        last_grant_q <= gnt_next;
                        write_q      <= cand_write;
                        len_q        <= cand_len;
                        cnt_q        <= '0;
                        rcnt_q       <= '0;
                        if (cand_bad) begin
                            state_q  <= StDone;
                            req_done <= next_oh;
                            req_err  <= next_oh;
                        end else begin
                            sram_address <= cand_addr;
                            if (cand_write) begin
                                state_q     <= StLoad;
                                wdata_ready <= next_oh;
                            end else begin
                                state_q            <= StIssue;
                                sram_read_cmd      <= 1'b1;
                                sram_read_cmd_size <= cand_len;
                            end
                        end
                    end
                end

                StLoad: begin
                    if (accept) begin
                        sram_data_in       <= wbyte;
                        sram_data_in_valid <= 1'b1;
                        cnt_q              <= cnt_q + 6'd1;
                        if (cnt_q + 6'd1 == len_q) begin
                            state_q <= StFlush;
                        end else begin
                            wdata_ready <= gnt_oh;
                        end
                    end else begin
                        wdata_ready <= gnt_oh;
                    end
                end

                StFlush: begin
                    // Last push is visible this cycle; command follows it
                    state_q        <= StIssue;
                    sram_write_cmd <= 1'b1;
                end

                StIssue: begin
                    state_q <= StSettle;
                end

                StSettle: begin
                    // sram_done may still be high from before the command
                    state_q <= StWait;
                end

                StWait: begin
                    if (sram_done) begin
                        if (write_q) begin
                            state_q  <= StDone;
                            req_done <= gnt_oh;
                        end else begin
                            state_q <= StDrain;
                            cnt_q   <= '0;
                            rcnt_q  <= '0;
                        end
                    end
                end

                StDrain: begin
                    if (!sram_data_out_empty && (cnt_q < len_q)) begin
                        sram_data_out_read <= 1'b1;
                        cnt_q              <= cnt_q + 6'd1;
                    end
                    if (pop_q) begin
                        rdata       <= sram_data_out;
                        rdata_valid <= gnt_oh;
                        rcnt_q      <= rcnt_q + 6'd1;
                        if (rcnt_q + 6'd1 == len_q) begin
                            req_done <= gnt_oh;
                            state_q  <= StDone;
                        end
                    end
                end

                StDone: begin
                    // req_done is visible this cycle; owner drops req by IDLE
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural spi_sram controller.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  req_write = '0;
    logic [47:0] req_addr = '0;
    logic [11:0] req_len = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wdata_valid = '0;
    logic [1:0]  wdata_ready;
    logic [7:0]  rdata;
    logic [1:0]  rdata_valid;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic        sram_done = 1'b0;
    logic [7:0]  sram_data_in;
    logic        sram_data_in_valid;
    logic [7:0]  sram_data_out = '0;
    logic        sram_data_out_read;
    logic        sram_data_out_empty = 1'b1;
    logic        sram_write_cmd;
    logic        sram_read_cmd;
    logic [5:0]  sram_read_cmd_size;
    logic [23:0] sram_address;

    always #5 clk = ~clk;

    sram_arbiter #(.MAX_LEN(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .wdata               (wdata),
        .wdata_valid         (wdata_valid),
        .wdata_ready         (wdata_ready),
        .rdata               (rdata),
        .rdata_valid         (rdata_valid),
        .req_done            (req_done),
        .req_err             (req_err),
        .sram_done           (sram_done),
        .sram_data_in        (sram_data_in),
        .sram_data_in_valid  (sram_data_in_valid),
        .sram_data_out       (sram_data_out),
        .sram_data_out_read  (sram_data_out_read),
        .sram_data_out_empty (sram_data_out_empty),
        .sram_write_cmd      (sram_write_cmd),
        .sram_read_cmd       (sram_read_cmd),
        .sram_read_cmd_size  (sram_read_cmd_size),
        .sram_address        (sram_address)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_push[$];
    logic [30:0] exp_cmd[$];   // {write, size, addr}
    logic [8:0]  exp_rd[$];    // {port, byte}
    logic [1:0]  exp_done[$];  // {port, err}

    logic [7:0] rd_base = 8'h00;
    logic [7:0] rd_step = 8'h00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, got);
    endtask

    // Controller model: init delay, command busy time, stale done in SETTLE
    int         init_cnt = 0;
    int         busy = 0;
    logic       rd_pend = 1'b0;
    logic [5:0] rd_len_m = '0;
    logic [7:0] fifo[$];

    always @(posedge clk) begin
        logic [7:0] v;
        if (init_cnt < 20) init_cnt <= init_cnt + 1;
        if (sram_write_cmd || sram_read_cmd) begin
            busy     <= 6;
            rd_pend  <= sram_read_cmd;
            rd_len_m <= sram_read_cmd_size;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 6) sram_done <= 1'b0;
            if (busy == 1) begin
                sram_done <= 1'b1;
                if (rd_pend) begin
                    v = rd_base;
                    for (int i = 0; i < int'(rd_len_m); i++) begin
                        fifo.push_back(v);
                        v = v + rd_step;
                    end
                end
                rd_pend <= 1'b0;
            end
        end else if (init_cnt == 14) begin
            sram_done <= 1'b1;
        end
        if (sram_data_out_read === 1'b1 && fifo.size() > 0) begin
            sram_data_out <= fifo.pop_front();
        end
        sram_data_out_empty <= (fifo.size() == 0);
    end

    // Monitor: every DUT output event is matched against the scoreboard
    always @(negedge clk) begin
        logic [30:0] c;
        logic [8:0]  r;
        logic [1:0]  d;
        logic [1:0]  oh;
        if (sram_data_in_valid === 1'b1) begin
            if (exp_push.size() == 0) fail_now("unexpected push", 64'(sram_data_in));
            else check("push byte", 64'(sram_data_in), 64'(exp_push.pop_front()));
        end
        if (sram_write_cmd === 1'b1 || sram_read_cmd === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                fail_now("unexpected cmd", 64'({sram_write_cmd, sram_read_cmd}));
            end else begin
                c = exp_cmd.pop_front();
                check("cmd strobes", 64'({sram_write_cmd, sram_read_cmd}),
                      64'({c[30], ~c[30]}));
                check("cmd addr", 64'(sram_address), 64'(c[23:0]));
                if (!c[30]) check("read size", 64'(sram_read_cmd_size), 64'(c[29:24]));
            end
        end
        if ((|rdata_valid) === 1'b1) begin
            if (exp_rd.size() == 0) begin
                fail_now("unexpected rdata", 64'({rdata_valid, rdata}));
            end else begin
                r  = exp_rd.pop_front();
                oh = r[8] ? 2'b10 : 2'b01;
                check("rdata port", 64'(rdata_valid), 64'(oh));
                check("rdata byte", 64'(rdata), 64'(r[7:0]));
            end
        end
        if ((|req_done) === 1'b1) begin
            if (exp_done.size() == 0) begin
                fail_now("unexpected done", 64'(req_done));
            end else begin
                d  = exp_done.pop_front();
                oh = d[1] ? 2'b10 : 2'b01;
                check("done port", 64'(req_done), 64'(oh));
                check("done err", 64'(req_err), 64'(d[0] ? oh : 2'b00));
            end
        end else if ((|req_err) === 1'b1) begin
            fail_now("err without done", 64'(req_err));
        end
    end

    task automatic expect_req(input int p, input bit wr, input logic [23:0] a,
                              input logic [5:0] l, input logic [7:0] b0,
                              input logic [7:0] rb, input logic [7:0] rs);
        logic [7:0] v;
        if (l == 6'd0 || l > 6'd16) begin
            exp_done.push_back({p[0], 1'b1});
        end else if (wr) begin
            for (int i = 0; i < int'(l); i++) exp_push.push_back(b0 + 8'(i));
            exp_cmd.push_back({1'b1, l, a});
            exp_done.push_back({p[0], 1'b0});
        end else begin
            exp_cmd.push_back({1'b0, l, a});
            v = rb;
            for (int i = 0; i < int'(l); i++) begin
                exp_rd.push_back({p[0], v});
                v = v + rs;
            end
            exp_done.push_back({p[0], 1'b0});
        end
    endtask

    task automatic run_req(input int p, input bit wr, input logic [23:0] a,
                           input logic [5:0] l, input logic [7:0] b0);
        int k;
        int t;
        @(posedge clk);
        #1;
        req_write[p]      = wr;
        req_addr[p*24+:24] = a;
        req_len[p*6+:6]   = l;
        req[p]            = 1'b1;
        if (wr && l != 6'd0 && l <= 6'd16) begin
            k = 0;
            t = 0;
            wdata[p*8+:8]  = b0;
            wdata_valid[p] = 1'b1;
            while (k < int'(l) && t < 1000) begin
                @(negedge clk);
                t++;
                if (wdata_ready[p] === 1'b1) begin
                    @(posedge clk);
                    #1;
                    k++;
                    // Keep offering a junk byte past the burst length
                    wdata[p*8+:8] = (k < int'(l)) ? b0 + 8'(k) : 8'hEE;
                end
            end
            if (k < int'(l)) fail_now("write accept timeout", 64'(k));
        end
        t = 0;
        while (req_done[p] !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now("done timeout", 64'(p));
        @(posedge clk);
        #1;
        req[p]         = 1'b0;
        wdata_valid[p] = 1'b0;
    endtask

    wire [57:0] all_out = {wdata_ready, rdata, rdata_valid, req_done, req_err, sram_data_in,
                           sram_data_in_valid, sram_data_out_read, sram_write_cmd,
                           sram_read_cmd, sram_read_cmd_size, sram_address};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t;
        // 1: reset held 10 cycles, outputs all zero
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset outputs", 64'(all_out), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        while (sram_done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("init done timeout", 64'(t));
        repeat (3) @(posedge clk);

        // 2: single-byte write from port 0
        expect_req(0, 1'b1, 24'h005678, 6'd1, 8'h9A, 8'h00, 8'h00);
        run_req(0, 1'b1, 24'h005678, 6'd1, 8'h9A);

        // 3: 16-byte read from port 1, controller returns 0xFF
        rd_base = 8'hFF;
        rd_step = 8'h00;
        expect_req(1, 1'b0, 24'h00FEDC, 6'd16, 8'h00, 8'hFF, 8'h00);
        run_req(1, 1'b0, 24'h00FEDC, 6'd16, 8'h00);

        // 4a: simultaneous requests after port 1 last -> port 0 first
        rd_base = 8'h40;
        rd_step = 8'h01;
        expect_req(0, 1'b1, 24'h000100, 6'd2, 8'h11, 8'h00, 8'h00);
        expect_req(1, 1'b0, 24'h000200, 6'd3, 8'h00, 8'h40, 8'h01);
        fork
            run_req(0, 1'b1, 24'h000100, 6'd2, 8'h11);
            run_req(1, 1'b0, 24'h000200, 6'd3, 8'h00);
        join
        // Port 0 alone, so port 1 wins the next tie
        expect_req(0, 1'b1, 24'h000300, 6'd1, 8'h21, 8'h00, 8'h00);
        run_req(0, 1'b1, 24'h000300, 6'd1, 8'h21);
        // 4b: simultaneous requests after port 0 last -> port 1 first
        rd_base = 8'h80;
        rd_step = 8'h03;
        expect_req(1, 1'b1, 24'h000500, 6'd3, 8'h31, 8'h00, 8'h00);
        expect_req(0, 1'b0, 24'h000400, 6'd2, 8'h00, 8'h80, 8'h03);
        fork
            run_req(0, 1'b0, 24'h000400, 6'd2, 8'h00);
            run_req(1, 1'b1, 24'h000500, 6'd3, 8'h31);
        join

        // 5: illegal lengths are rejected without touching the controller
        expect_req(0, 1'b1, 24'h000010, 6'd0, 8'h00, 8'h00, 8'h00);
        run_req(0, 1'b1, 24'h000010, 6'd0, 8'h00);
        expect_req(0, 1'b0, 24'h000020, 6'd17, 8'h00, 8'h00, 8'h00);
        run_req(0, 1'b0, 24'h000020, 6'd17, 8'h00);

        // 6: reset after 3 of 8 write bytes; only those 3 pushes appear
        for (int i = 0; i < 3; i++) exp_push.push_back(8'h61 + 8'(i));
        @(posedge clk);
        #1;
        req_write[0]   = 1'b1;
        req_addr[23:0] = 24'h000777;
        req_len[5:0]   = 6'd8;
        req[0]         = 1'b1;
        wdata[7:0]     = 8'h61;
        wdata_valid[0] = 1'b1;
        k = 0;
        t = 0;
        while (k < 3 && t < 1000) begin
            @(negedge clk);
            t++;
            if (wdata_ready[0] === 1'b1) begin
                @(posedge clk);
                #1;
                k++;
                wdata[7:0] = 8'h61 + 8'(k);
            end
        end
        if (k < 3) fail_now("partial write timeout", 64'(k));
        rst            = 1'b1;
        req[0]         = 1'b0;
        wdata_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("outputs after mid-burst reset", 64'(all_out), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Arbiter works again after the abandoned burst
        expect_req(1, 1'b1, 24'hABCDEF, 6'd2, 8'h55, 8'h00, 8'h00);
        run_req(1, 1'b1, 24'hABCDEF, 6'd2, 8'h55);
        repeat (10) @(posedge clk);

        check("push queue drained", 64'(exp_push.size()), 64'd0);
        check("cmd queue drained", 64'(exp_cmd.size()), 64'd0);
        check("rdata queue drained", 64'(exp_rd.size()), 64'd0);
        check("done queue drained", 64'(exp_done.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
